// File: rtl/axis_rx_frame_checker.sv
// AXI-Stream receive frame checker: length, payload pattern and strobe checks with stats.
// Define AXIS_RX_THROTTLE_EN for LFSR-driven pseudo-random backpressure on tready.
module axis_rx_frame_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514
) (
  input  logic                    rx_mac_aclk,
  input  logic                    reset,
  input  logic                    rx_en,
  input  logic                    pat_chk_en,
  input  logic                    cnt_clr,
  input  logic [DATA_WIDTH-1:0]   rx_axis_mac_tdata,
  input  logic                    rx_axis_mac_tvalid,
  input  logic                    rx_axis_mac_tlast,
  input  logic                    rx_axis_mac_tuser,
  input  logic [DATA_WIDTH/8-1:0] rx_axis_mac_tstrb,
  output logic                    rx_axis_mac_tready,
  output logic                    frame_done,
  output logic [15:0]             last_len,
  output logic [3:0]              last_status,
  output logic [31:0]             frame_cnt,
  output logic [31:0]             byte_cnt,
  output logic [15:0]             err_cnt,
  output logic [15:0]             pat_err_cnt,
  output logic [15:0]             strb_err_cnt
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic tready_q, tready_d;
  logic accept;
  logic frame_start;
  logic frame_end;

  logic [15:0] len_q, len_d;
  logic [7:0]  pos_q, pos_d;
  logic [7:0]  seed_q, seed_d;
  logic        pen_q, pen_d;
  logic        perr_q, perr_d;

  logic [CW-1:0] beat_bytes;
  logic [NB-1:0] strb_p1;
  logic          strb_ok;
  logic          pat_mm;
  logic [15:0]   len_base;
  logic [16:0]   len_sum;
  logic [15:0]   len_nxt;
  logic [7:0]    pos_base;
  logic [7:0]    seed_cur;
  logic          pen_cur;
  logic          perr_nxt;
  logic          runt;
  logic          oversize;
  logic [3:0]    status_nxt;

  logic        done_q, done_d;
  logic [15:0] last_len_q, last_len_d;
  logic [3:0]  status_q, status_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] bcnt_q, bcnt_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] scnt_q, scnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  assign accept = rx_axis_mac_tvalid & tready_q;

  // ---------------- ready generation ----------------
`ifdef AXIS_RX_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d   = {lfsr_q[14:0], lfsr_fb};
  assign tready_d = rx_en & (lfsr_q[1:0] != 2'b00);

  always_ff @(posedge rx_mac_aclk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign tready_d = rx_en;
`endif

  always_ff @(posedge rx_mac_aclk or posedge reset) begin
    if (reset) begin
      tready_q <= 1'b0;
    end else begin
      tready_q <= tready_d;
    end
  end

  // ---------------- frame FSM ----------------
  always_ff @(posedge rx_mac_aclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !rx_axis_mac_tlast) begin
          state_d = S_FRAME;
        end
      end
      S_FRAME: begin
        if (accept && rx_axis_mac_tlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    frame_start = accept & (state_q == S_IDLE);
    frame_end   = accept & rx_axis_mac_tlast;
  end

  // ---------------- beat datapath ----------------
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < NB; i++) begin
      beat_bytes = beat_bytes + CW'(rx_axis_mac_tstrb[i]);
    end
  end

  // A last-beat strobe is legal when it is a non-zero run of ones from lane 0.
  assign strb_p1 = rx_axis_mac_tstrb + NB'(1);
  assign strb_ok = rx_axis_mac_tlast
                 ? ((|rx_axis_mac_tstrb) & ~(|(rx_axis_mac_tstrb & strb_p1)))
                 : (&rx_axis_mac_tstrb);

  assign len_base = frame_start ? 16'd0 : len_q;
  assign len_sum  = {1'b0, len_base} + 17'(beat_bytes);
  assign len_nxt  = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  assign pos_base = frame_start ? 8'd0 : pos_q;
  assign seed_cur = frame_start ? rx_axis_mac_tdata[7:0] : seed_q;
  assign pen_cur  = frame_start ? pat_chk_en : pen_q;

  always_comb begin
    pat_mm = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (rx_axis_mac_tstrb[i] &&
          (rx_axis_mac_tdata[8*i +: 8] != 8'(seed_cur + pos_base + 8'(i)))) begin
        pat_mm = 1'b1;
      end
    end
  end

  assign perr_nxt = (~frame_start & perr_q) | (pen_cur & pat_mm) | ~strb_ok;

  assign runt       = len_nxt < 16'(MIN_LEN);
  assign oversize   = (len_nxt > 16'(MAX_LEN)) | (&len_nxt);
  assign status_nxt = {oversize, runt, perr_nxt, rx_axis_mac_tuser};

  always_comb begin
    len_d  = len_q;
    pos_d  = pos_q;
    seed_d = seed_q;
    pen_d  = pen_q;
    perr_d = perr_q;
    if (accept) begin
      len_d  = len_nxt;
      pos_d  = pos_base + 8'(beat_bytes);
      seed_d = seed_cur;
      pen_d  = pen_cur;
      perr_d = perr_nxt;
    end
  end

  always_ff @(posedge rx_mac_aclk or posedge reset) begin
    if (reset) begin
      len_q  <= '0;
      pos_q  <= '0;
      seed_q <= '0;
      pen_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      pos_q  <= pos_d;
      seed_q <= seed_d;
      pen_q  <= pen_d;
      perr_q <= perr_d;
    end
  end

  // ---------------- status and statistics ----------------
  // A clear wins over a completing frame, but the done pulse is kept.
  always_comb begin
    done_d     = frame_end;
    last_len_d = last_len_q;
    status_d   = status_q;
    fcnt_d     = fcnt_q;
    bcnt_d     = bcnt_q;
    ecnt_d     = ecnt_q;
    pcnt_d     = pcnt_q;
    scnt_d     = scnt_q;
    if (cnt_clr) begin
      last_len_d = '0;
      status_d   = '0;
      fcnt_d     = '0;
      bcnt_d     = '0;
      ecnt_d     = '0;
      pcnt_d     = '0;
      scnt_d     = '0;
    end else begin
      if (accept && !strb_ok) begin
        scnt_d = sat_inc(scnt_q);
      end
      if (frame_end) begin
        last_len_d = len_nxt;
        status_d   = status_nxt;
        fcnt_d     = fcnt_q + 32'd1;
        bcnt_d     = bcnt_q + 32'(len_nxt);
        if (|status_nxt) begin
          ecnt_d = sat_inc(ecnt_q);
        end
        if (perr_nxt) begin
          pcnt_d = sat_inc(pcnt_q);
        end
      end
    end
  end

  always_ff @(posedge rx_mac_aclk or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b0;
      last_len_q <= '0;
      status_q   <= '0;
      fcnt_q     <= '0;
      bcnt_q     <= '0;
      ecnt_q     <= '0;
      pcnt_q     <= '0;
      scnt_q     <= '0;
    end else begin
      done_q     <= done_d;
      last_len_q <= last_len_d;
      status_q   <= status_d;
      fcnt_q     <= fcnt_d;
      bcnt_q     <= bcnt_d;
      ecnt_q     <= ecnt_d;
      pcnt_q     <= pcnt_d;
      scnt_q     <= scnt_d;
    end
  end

  assign rx_axis_mac_tready = tready_q;
  assign frame_done         = done_q;
  assign last_len           = last_len_q;
  assign last_status        = status_q;
  assign frame_cnt          = fcnt_q;
  assign byte_cnt           = bcnt_q;
  assign err_cnt            = ecnt_q;
  assign pat_err_cnt        = pcnt_q;
  assign strb_err_cnt       = scnt_q;

endmodule

// File: tb/tb_axis_rx_frame_checker.sv
// Bench for axis_rx_frame_checker: directed frames plus randomized traffic
// compared every cycle against a frame-level byte-queue model.
module tb_axis_rx_frame_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_en = 1'b0;
  logic        pat_chk_en = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic [7:0]  tstrb = '0;

  logic        tready;
  logic        frame_done;
  logic [15:0] last_len;
  logic [3:0]  last_status;
  logic [31:0] frame_cnt;
  logic [31:0] byte_cnt;
  logic [15:0] err_cnt;
  logic [15:0] pat_err_cnt;
  logic [15:0] strb_err_cnt;

  int tests = 0;
  int fails = 0;
  bit rnd = 0;

  axis_rx_frame_checker dut (
    .rx_mac_aclk        (clk),
    .reset              (reset),
    .rx_en              (rx_en),
    .pat_chk_en         (pat_chk_en),
    .cnt_clr            (cnt_clr),
    .rx_axis_mac_tdata  (tdata),
    .rx_axis_mac_tvalid (tvalid),
    .rx_axis_mac_tlast  (tlast),
    .rx_axis_mac_tuser  (tuser),
    .rx_axis_mac_tstrb  (tstrb),
    .rx_axis_mac_tready (tready),
    .frame_done         (frame_done),
    .last_len           (last_len),
    .last_status        (last_status),
    .frame_cnt          (frame_cnt),
    .byte_cnt           (byte_cnt),
    .err_cnt            (err_cnt),
    .pat_err_cnt        (pat_err_cnt),
    .strb_err_cnt       (strb_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic        m_tready, m_done;
  logic [15:0] m_len;
  logic [3:0]  m_status;
  logic [31:0] m_fcnt, m_bcnt;
  logic [15:0] m_ecnt, m_pcnt, m_scnt;
  bit          in_frame, fbad, fpat;
  logic [7:0]  fq[$];

  task automatic m_reset();
    m_tready = 0; m_done = 0; m_len = 0; m_status = 0;
    m_fcnt = 0; m_bcnt = 0; m_ecnt = 0; m_pcnt = 0; m_scnt = 0;
    in_frame = 0; fbad = 0; fpat = 0;
    fq.delete();
  endtask

  task automatic m_step();
    bit acc, legal, perr;
    int len;
    acc = tvalid && tready;
    legal = 1;
    if (acc) begin
      if (!in_frame) begin
        fq.delete();
        fbad = 0;
        fpat = pat_chk_en;
      end
      for (int j = 0; j < 8; j++)
        if (tstrb[j]) fq.push_back(tdata[8*j +: 8]);
      if (tlast)
        legal = tstrb inside {8'h01, 8'h03, 8'h07, 8'h0F,
                              8'h1F, 8'h3F, 8'h7F, 8'hFF};
      else
        legal = (tstrb == 8'hFF);
      if (!legal) fbad = 1;
      in_frame = !tlast;
    end
    if (cnt_clr) begin
      m_len = 0; m_status = 0;
      m_fcnt = 0; m_bcnt = 0; m_ecnt = 0; m_pcnt = 0; m_scnt = 0;
    end else begin
      if (acc && !legal && m_scnt != 16'hFFFF) m_scnt++;
      if (acc && tlast) begin
        len = (fq.size() > 65535) ? 65535 : fq.size();
        perr = fbad;
        if (fpat)
          foreach (fq[k])
            if (fq[k] != 8'(fq[0] + k)) perr = 1;
        m_len = 16'(len);
        m_status = {len > 1514, len < 60, perr, tuser};
        m_fcnt++;
        m_bcnt += 32'(len);
        if (m_status != 0 && m_ecnt != 16'hFFFF) m_ecnt++;
        if (perr && m_pcnt != 16'hFFFF) m_pcnt++;
      end
    end
    m_done = acc && tlast;
    m_tready = rx_en;
  endtask

  always @(negedge clk) begin
    if (reset) m_reset();
`ifndef AXIS_RX_THROTTLE_EN
    chk("tready", tready, m_tready);
`endif
    chk("frame_done", frame_done, m_done);
    chk("last_len", last_len, m_len);
    chk("last_status", last_status, m_status);
    chk("frame_cnt", frame_cnt, m_fcnt);
    chk("byte_cnt", byte_cnt, m_bcnt);
    chk("err_cnt", err_cnt, m_ecnt);
    chk("pat_err_cnt", pat_err_cnt, m_pcnt);
    chk("strb_err_cnt", strb_err_cnt, m_scnt);
    if (!reset) m_step();
  end

  // ---------------- stimulus ----------------
  function automatic logic [63:0] mkb(input logic [7:0] seed, input int base);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = seed + 8'(base + j);
    return r;
  endfunction

  task automatic beat(input logic [63:0] d, input logic [7:0] s,
                      input logic l, input logic u);
    int n;
    logic ok;
    tdata = d; tstrb = s; tlast = l; tuser = u; tvalid = 1;
    n = 0;
    do begin
      if (rnd) begin
        rx_en = ($urandom_range(0, 9) != 0);
        pat_chk_en = 1'($urandom_range(0, 1));
        cnt_clr = ($urandom_range(0, 29) == 0);
      end
      @(negedge clk);
      ok = tready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    chk("beat_accept", ok, 1);
    tvalid = 0;
  endtask

  task automatic idle(input int n);
    tvalid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cnt_clr = 1;
    @(posedge clk);
    #1;
    cnt_clr = 0;
    chk("clr_fcnt", frame_cnt, 0);
  endtask

  task automatic send_frame(input int len, input logic [7:0] seed, input int bad,
                            input logic u, input int gap, input logic clr_last);
    logic [63:0] d;
    logic [7:0]  s, v;
    int nb, rem, k;
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++) begin
        k = b * 8 + j;
        v = (k < len) ? seed + 8'(k) : 8'($urandom);
        if (k == bad) v = ~v;
        d[8*j +: 8] = v;
      end
      rem = len - b * 8;
      s = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      if (rnd && $urandom_range(0, 39) == 0) s = 8'($urandom);
      if (gap > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap));
      if (b == nb - 1 && clr_last) cnt_clr = 1;
      beat(d, s, 1'(b == nb - 1), u);
      if (!rnd) cnt_clr = 0;
    end
  endtask

  initial begin
    rx_en = 1;
    pat_chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_status", last_status, 0);
    reset = 0;
    @(posedge clk);
    #1;
`ifndef AXIS_RX_THROTTLE_EN
    chk("tready_up", tready, 1);
`endif

    // 60-byte good frame
    send_frame(60, 8'h10, -1, 0, 0, 0);
    chk("f60_done", frame_done, 1);
    chk("f60_len", last_len, 60);
    chk("f60_status", last_status, 4'b0000);
    chk("f60_fcnt", frame_cnt, 1);
    chk("f60_bcnt", byte_cnt, 60);
    chk("f60_ecnt", err_cnt, 0);

    // runt then oversize, back-to-back
    clr();
    send_frame(59, 8'h33, -1, 0, 0, 0);
    chk("runt_status", last_status, 4'b0100);
    chk("runt_len", last_len, 59);
    send_frame(1515, 8'h77, -1, 0, 0, 0);
    chk("over_status", last_status, 4'b1000);
    chk("over_len", last_len, 1515);
    chk("over_ecnt", err_cnt, 2);
    chk("over_fcnt", frame_cnt, 2);

    // corrupted byte with and without pattern checking
    clr();
    send_frame(64, 8'h20, 20, 0, 0, 0);
    chk("pat_status", last_status, 4'b0010);
    chk("pat_pcnt", pat_err_cnt, 1);
    clr();
    pat_chk_en = 0;
    send_frame(64, 8'h20, 20, 0, 0, 0);
    chk("nopat_status", last_status, 4'b0000);
    chk("nopat_pcnt", pat_err_cnt, 0);
    pat_chk_en = 1;

    // illegal strobes
    clr();
    beat(mkb(8'h50, 0), 8'h7F, 0, 0);
    beat(mkb(8'h50, 7), 8'h05, 1, 0);
    chk("strb_scnt", strb_err_cnt, 2);
    chk("strb_status", last_status, 4'b0110);
    chk("strb_len", last_len, 9);

    // clear coinciding with completion
    send_frame(80, 8'h01, -1, 1, 0, 1);
    chk("clr_done", frame_done, 1);
    chk("clr_fcnt0", frame_cnt, 0);
    chk("clr_bcnt0", byte_cnt, 0);
    chk("clr_len0", last_len, 0);
    send_frame(100, 8'h02, -1, 0, 0, 0);
    chk("after_clr_fcnt", frame_cnt, 1);
    chk("after_clr_bcnt", byte_cnt, 100);

    // reset after 3 beats of a 64-byte frame
    for (int b = 0; b < 3; b++) beat(mkb(8'h40, b * 8), 8'hFF, 0, 0);
    reset = 1;
    #1;
    chk("mid_rst_tready", tready, 0);
    chk("mid_rst_fcnt", frame_cnt, 0);
    chk("mid_rst_bcnt", byte_cnt, 0);
    @(posedge clk);
    #1;
    reset = 0;
    for (int b = 3; b < 8; b++) beat(mkb(8'h40, b * 8), 8'hFF, 1'(b == 7), 0);
    chk("tail_len", last_len, 40);
    chk("tail_status", last_status, 4'b0100);
    chk("tail_fcnt", frame_cnt, 1);

    // randomized traffic
    rnd = 1;
    for (int f = 0; f < 150; f++) begin
      int len, bad;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(1400, 1600)
                                        : $urandom_range(1, 130);
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      send_frame(len, 8'($urandom), bad, ($urandom_range(0, 7) == 0), 3, 0);
    end
    rnd = 0;
    cnt_clr = 0;
    rx_en = 1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_rx_frame_checker.md
# axis_rx_frame_checker

Downstream consumer of the LMAC receive AXI-Stream (`rx_axis_mac_*`) in the LMAC bench and bring-up builds. It drives `rx_axis_mac_tready` and accepts frames beat by beat. For each frame it measures the length, checks an incrementing payload pattern and tags it as good, errored, runt or oversize. It keeps saturating and wrapping statistics counters that software or the bench can read and clear.

## Interface
- `DATA_WIDTH`, 64: AXIS data width; only 64 is supported, giving 8 byte lanes.
- `MIN_LEN`, 60: minimum legal frame length in bytes, FCS excluded.
- `MAX_LEN`, 1514: maximum legal frame length in bytes, FCS excluded.
- `rx_mac_aclk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_en` in 1: while 1 the block may assert tready; while 0, tready is 0.
- `pat_chk_en` in 1: enables the payload pattern check.
- `cnt_clr` in 1: synchronous clear of all counters and last-frame status.
- `rx_axis_mac_tdata` in 64: receive data; byte k is at `[8k+7:8k]`.
- `rx_axis_mac_tvalid` in 1: data valid.
- `rx_axis_mac_tlast` in 1: last beat of the frame.
- `rx_axis_mac_tuser` in 1: MAC error flag; sampled only on the tlast beat.
- `rx_axis_mac_tstrb` in 8: byte-valid lanes.
- `rx_axis_mac_tready` out 1: registered ready.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `last_len` out 16: byte length of the most recent frame.
- `last_status` out 4: flags for the most recent frame: {oversize, runt, pattern_err, tuser}.
- `frame_cnt` out 32: total completed frames; wraps.
- `byte_cnt` out 32: total accepted bytes; wraps.
- `err_cnt` out 16: frames with any status flag set; saturates at 0xFFFF.
- `pat_err_cnt` out 16: frames with a pattern error; saturates.
- `strb_err_cnt` out 16: beats with an illegal tstrb; saturates.

## Operation
- A beat is accepted when `tvalid & tready`. Nothing changes on cycles without an accepted beat.
- FSM states:
  - IDLE: waiting for the first beat. An accepted beat with tlast=0 moves to FRAME. An accepted beat with tlast=1 completes a one-beat frame and stays in IDLE.
  - FRAME: mid-frame. An accepted tlast beat moves to IDLE.
- Beat byte count = popcount(tstrb).
- Legal tstrb values:
  - On a non-last beat: 8'hFF.
  - On a last beat: contiguous from bit 0, i.e. 8'h01, 8'h03 … 8'hFF.
- Illegal tstrb handling:
  - Increment `strb_err_cnt`.
  - Still count popcount(tstrb) bytes.
  - Force pattern_err for that frame.
- Frame length:
  - A 16-bit accumulator, cleared at frame start, that saturates at 0xFFFF.
  - Saturation implies oversize.
- Pattern check (when `pat_chk_en`=1):
  - Seed = byte 0 of the frame.
  - Expected byte k = (seed + k) mod 256.
  - Only lanes with strb=1 are compared.
  - Any mismatch sets pattern_err.
  - `pat_chk_en` is sampled at frame start and held for the whole frame.
- Status flags at frame completion:
  - runt = len < MIN_LEN.
  - oversize = len > MAX_LEN.
  - tuser = tuser on the tlast beat.
- Counter updates on `frame_done`:
  - `frame_cnt` += 1.
  - `byte_cnt` += len.
  - `err_cnt` += 1 if any flag is set.
  - `pat_err_cnt` += 1 if pattern_err is set.
- `cnt_clr`:
  - Zeroes all counters, `last_len` and `last_status`.
  - It takes precedence over a simultaneous completion: the completing frame is not counted, and `frame_done` still pulses.
  - It does not alter the in-frame state.
- Mid-frame reset: everything returns to reset values. The remainder of the aborted frame is accepted as a new frame.

## Timing
- Reset values:
  - `tready`=0 and `frame_done`=0.
  - All counters, `last_len` and `last_status` = 0.
  - FSM in IDLE.
- `tready` is registered: it becomes 1 on the first edge after reset deasserts with `rx_en`=1. It follows `rx_en` with one cycle of latency.
- `frame_done`, `last_len`, `last_status` and all counters update on the edge after the tlast beat is accepted, giving one cycle of latency.
- Back-to-back frames with zero idle cycles are supported. A new frame's first beat may be accepted on the cycle right after the tlast beat.
- `byte_cnt` has no additional latency beyond the frame_done edge.

## Configuration
- `AXIS_RX_THROTTLE_EN`
  - Defined:
    - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 at reset, advances every cycle.
    - Registered `tready` = `rx_en & (lfsr[1:0] != 2'b00)`, giving about 25% pseudo-random backpressure.
  - Undefined: `tready` = `rx_en` (registered); the block is always ready when enabled.

## Test plan
- 60-byte frame: 7 full beats plus a last beat with tstrb=8'h0F, pattern seed 0x10, tuser=0.
  - One `frame_done` pulse; `last_len`=60; `last_status`=0.
  - `frame_cnt`=1; `byte_cnt`=60; `err_cnt`=0.
- 59-byte frame (last tstrb=8'h07) followed by a 1515-byte frame, back-to-back:
  - `last_status` reads 4'b0100 for the first frame, then 4'b1000 for the second.
  - `err_cnt`=2 and `frame_cnt`=2.
- 64-byte frame with byte 20 corrupted and `pat_chk_en`=1:
  - pattern_err set; `pat_err_cnt`=1.
  - Same frame with `pat_chk_en`=0 gives `pat_err_cnt`=0.
- Non-last beat with tstrb=8'h7F, and a last beat with tstrb=8'h05:
  - `strb_err_cnt`=2; pattern_err flagged.
- `cnt_clr` asserted on the `frame_done` cycle:
  - All counters read 0 the next cycle.
  - The next 100-byte frame gives `frame_cnt`=1 and `byte_cnt`=100.
- Reset asserted mid-frame, after 3 beats:
  - `tready`=0 and counters 0 immediately.
  - After release, 5 remaining beats ending in tlast produce one frame with len=40, runt flagged.
